// File: rtl/reg_register_cnt_bank_if.sv
// Register access bus shared by the field registers: select, direction, address,
// write data and the combinational read-data return.
interface reg_register_cnt_bank_if #(
  parameter int REG_WIDTH  = 32,
  parameter int ADDR_WIDTH = 2
);
  logic                  reg_wr_sel;
  logic                  reg_wr_rd;
  logic [ADDR_WIDTH-1:0] reg_addr;
  logic [REG_WIDTH-1:0]  reg_wr_data;
  logic [REG_WIDTH-1:0]  reg_rd_out;

  modport master (
    output reg_wr_sel, reg_wr_rd, reg_addr, reg_wr_data,
    input  reg_rd_out
  );

  modport slave (
    input  reg_wr_sel, reg_wr_rd, reg_addr, reg_wr_data,
    output reg_rd_out
  );
endinterface

// File: rtl/reg_register_cnt_bank.sv
// Bank of CH_NUM saturating event counters with sticky saturation flags, preload on
// write and optional clear-on-read (enabled by defining REG_CNT_BANK_CLR_ON_RD_EN).
module reg_register_cnt_bank #(
  parameter int REG_WIDTH  = 32,
  parameter int CH_NUM     = 4,
  parameter int CNT_WIDTH  = 16,
  parameter int ADDR_WIDTH = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [CH_NUM-1:0]     cnt_inc_i,
  reg_register_cnt_bank_if.slave bus,
  output logic [CH_NUM-1:0]     cnt_rd_pulse_o,
  output logic [CH_NUM-1:0]     cnt_sat_o
);

`ifdef REG_CNT_BANK_CLR_ON_RD_EN
  localparam bit ClrOnRd = 1'b1;
`else
  localparam bit ClrOnRd = 1'b0;
`endif

  logic                             wrEn;
  logic                             rdEn;
  logic [CH_NUM-1:0]                chSel;
  logic [CH_NUM-1:0]                wrHit;
  logic [CH_NUM-1:0]                rdHit;
  logic [CH_NUM-1:0][CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [CH_NUM-1:0]                sat_q, sat_d;
  logic [CH_NUM-1:0]                pulse_q, pulse_d;
  logic                             unusedWrBits;

  assign wrEn = bus.reg_wr_sel &  bus.reg_wr_rd;
  assign rdEn = bus.reg_wr_sel & ~bus.reg_wr_rd;

  // Addresses at or above CH_NUM select no channel, which makes them inert.
  always_comb begin
    chSel = '0;
    for (int i = 0; i < CH_NUM; i++) begin
      chSel[i] = (bus.reg_addr == ADDR_WIDTH'(i));
    end
  end

  assign wrHit = chSel & {CH_NUM{wrEn}};
  assign rdHit = chSel & {CH_NUM{rdEn}};

  always_comb begin
    bus.reg_rd_out = '0;
    for (int i = 0; i < CH_NUM; i++) begin
      if (rdHit[i]) begin
        bus.reg_rd_out[CNT_WIDTH-1:0] = cnt_q[i];
        bus.reg_rd_out[REG_WIDTH-1]   = sat_q[i];
      end
    end
  end

  // Write beats read-clear beats increment; a clearing read keeps a coincident event.
  always_comb begin
    cnt_d   = cnt_q;
    sat_d   = sat_q;
    pulse_d = rdHit;
    for (int i = 0; i < CH_NUM; i++) begin
      if (wrHit[i]) begin
        cnt_d[i] = bus.reg_wr_data[CNT_WIDTH-1:0];
        sat_d[i] = 1'b0;
      end else if (ClrOnRd && rdHit[i]) begin
        cnt_d[i] = cnt_inc_i[i] ? CNT_WIDTH'(1) : '0;
        sat_d[i] = 1'b0;
      end else if (cnt_inc_i[i]) begin
        if (cnt_q[i] != '1) begin
          cnt_d[i] = cnt_q[i] + CNT_WIDTH'(1);
        end else begin
          sat_d[i] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      sat_q   <= '0;
      pulse_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      sat_q   <= sat_d;
      pulse_q <= pulse_d;
    end
  end

  assign cnt_rd_pulse_o = pulse_q;
  assign cnt_sat_o      = sat_q;
  assign unusedWrBits   = ^bus.reg_wr_data[REG_WIDTH-1:CNT_WIDTH];

endmodule
